// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 peripheral exposing NUM_REGS registers of DATA_W bits.
// Frame (MSB first): R/W (1 = write), ADDR_W address bits, DATA_W data bits.
// Read frames return the addressed register on cipo during the data phase.
// All SPI pins are synchronised into clk; the module has no other clock.
module spi_regfile #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;
  localparam logic [1:0] COMMIT    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
  // count value just before the last header bit arrives
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(ADDR_W);
  // count value once the whole header has arrived
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADDR_W + 1);
  localparam logic [ADDR_W:0]  NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_s1, sclk_s2, sclk_d;
  logic ncs_s1, ncs_s2, ncs_d;
  logic copi_s1, copi_s2, copi_d;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  logic [1:0]         state;
  logic [1:0]         settle;
  logic [CNT_W-1:0]   count;
  logic [FRAME_W-1:0] shift_in;
  logic [FRAME_W-1:0] shift_next;
  logic [DATA_W-1:0]  shift_out;
  logic [DATA_W-1:0]  rd_data;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic               frame_rw;
  logic               frame_addr_ok;
  logic               commit_we;

  logic [DATA_W-1:0]  regs [NUM_REGS];

  // Two-stage synchronisers plus one delay flop per pin for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
      ncs_s1  <= 1'b1; ncs_s2  <= 1'b1; ncs_d  <= 1'b1;
      copi_s1 <= 1'b0; copi_s2 <= 1'b0; copi_d <= 1'b0;
    end else begin
      sclk_s1 <= sclk; sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
      ncs_s1  <= ncs;  ncs_s2  <= ncs_s1;  ncs_d  <= ncs_s2;
      copi_s1 <= copi; copi_s2 <= copi_s1; copi_d <= copi_s2;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign ncs_rise  = ncs_s2 & ~ncs_d;
  assign ncs_fall  = ~ncs_s2 & ncs_d;

  // copi_d is one cycle older than the edge; the bit is long stable by then
  assign shift_next    = {shift_in[FRAME_W-2:0], copi_d};
  assign rd_addr       = shift_next[ADDR_W-1:0];
  assign frame_rw      = shift_in[FRAME_W-1];
  assign frame_addr    = shift_in[DATA_W +: ADDR_W];
  assign frame_data    = shift_in[DATA_W-1:0];
  assign frame_addr_ok = {1'b0, frame_addr} < NUM_REGS_X;
  assign commit_we     = (state == COMMIT) && (count == CNT_FULL) && frame_rw && frame_addr_ok;
  assign cipo          = shift_out[DATA_W-1];

  // Read-back mux; unimplemented addresses return zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs[i];
    end
  end

  // Frame FSM: bit counting, shift registers, read load and commit pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WAIT_IDLE;
      settle    <= 2'd0;
      count     <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      cipo_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          // let the synchroniser flush its reset value before trusting ncs,
          // so a frame already in progress at reset release is not picked up
          if (settle != 2'd3) settle <= settle + 2'd1;
          else if (ncs_s2) state <= IDLE;
        end
        IDLE: begin
          if (ncs_fall) begin
            count    <= '0;
            shift_in <= '0;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ncs_rise) begin
            // end of frame takes priority over a coincident sclk edge
            state     <= COMMIT;
            cipo_oe   <= 1'b0;
            shift_out <= '0;
          end else if (sclk_rise) begin
            if (count < CNT_FULL) shift_in <= shift_next;
            if (count != CNT_SAT) count <= count + CNT_ONE;
            if ((count == CNT_HDR) && !shift_next[ADDR_W]) begin
              shift_out <= rd_data;
              cipo_oe   <= 1'b1;
            end
          end else if (sclk_fall && (count > CNT_LOAD)) begin
            // the fall right after the load is skipped so the MSB is
            // presented for the first data-phase rising edge
            shift_out <= shift_out << 1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          if (count != CNT_FULL) begin
            frame_err <= 1'b1;
          end else if (frame_rw && frame_addr_ok) begin
            wr_strobe <= 1'b1;
            wr_addr   <= frame_addr;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // Register bank: written only by a complete, in-range write frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (frame_addr == ADDR_W'(i)) regs[i] <= frame_data;
      end
    end
  end

  // Flatten the bank for the downstream PWM / output-enable logic
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*DATA_W +: DATA_W] = regs[gi];
    end
  endgenerate

endmodule

// File: doc/spi_regfile.md
# spi_regfile

Parametrised SPI (mode 0) peripheral exposing a bank of NUM_REGS control registers to an external controller, with both write and read-back frames. It succeeds the fixed five-register write-only peripheral. Register width, address width and bank depth are generic, and a read path drives CIPO. It sits between the chip's SPI pins and the PWM/output-enable logic, which consumes the flattened register bus.

## Interface
- NUM_REGS, 8: number of implemented registers, 1..2^ADDR_W.
- ADDR_W, 7: address field width in bits.
- DATA_W, 8: register and data field width in bits.
- FRAME_W (localparam) = 1 + ADDR_W + DATA_W; 16 at defaults.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- sclk  in  1  SPI clock, asynchronous to clk.
- ncs  in  1  SPI chip select, active-low, asynchronous.
- copi  in  1  SPI controller-out data, asynchronous.
- cipo  out  1  SPI peripheral-out data; 0 when not driving.
- cipo_oe  out  1  high while cipo carries read data.
- regs_flat  out  NUM_REGS*DATA_W  register contents; reg i at [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-cycle pulse when a write commits.
- wr_addr  out  ADDR_W  address of last committed write; holds its value.
- frame_err  out  1  one-cycle pulse when a frame ends with bit count != FRAME_W.

## Operation
- sclk, ncs and copi each pass through a 2-FF synchroniser, then one delay flop for edge detection. The ncs flops reset to 1; the others reset to 0. All logic runs in clk.
- Frame is sent MSB first. Bit FRAME_W-1 is R/W (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits. copi is sampled on synced sclk rising edges.
- FSM states:
  - WAIT_IDLE (reset state): go to IDLE once synced ncs = 1.
  - IDLE: a synced ncs falling edge clears the bit counter and shift-in register, then goes to ACTIVE.
  - ACTIVE: each sclk rising edge shifts copi into shift-in and increments the counter, which saturates at FRAME_W+1. A synced ncs rising edge goes to COMMIT.
  - COMMIT: one cycle, then IDLE.
- COMMIT:
  - If count == FRAME_W and R/W = 1 and address < NUM_REGS: the register takes the data field, wr_strobe = 1, and wr_addr = address.
  - If count != FRAME_W: frame_err = 1 and no register changes.
  - Out-of-range writes and read frames have no effect.
- Bits after the FRAME_W-th are not shifted in, so shift-in holds the first FRAME_W bits.
- Read frames:
  - When the counter reaches 1+ADDR_W with R/W = 0, load shift-out with reg[address], or 0 if address >= NUM_REGS. Set cipo_oe = 1.
  - cipo = shift-out MSB.
  - On each sclk falling edge while counter > 1+ADDR_W, shift-out shifts left, filling with 0. No shift occurs on the falling edge immediately after the load, so data bit MSB is valid for the first data-phase rising edge.
  - cipo_oe and cipo return to 0 on leaving ACTIVE.
- Reset values: every register 0, so regs_flat = 0. cipo = 0, cipo_oe = 0, wr_strobe = 0, wr_addr = 0, frame_err = 0. The FSM starts in WAIT_IDLE.
- Reset mid-frame discards the frame. If ncs is still low at reset release, that frame is ignored, because WAIT_IDLE requires ncs high first.

## Timing
- Input-to-detected-edge latency is 3 clk cycles.
- sclk high and low phases must each be at least 4 clk cycles.
- ncs setup to the first sclk rise and hold after the last sclk fall must each be at least 4 clk cycles.
- Write commit: regs_flat and wr_strobe update in the cycle after the synced ncs rising edge is detected, i.e. 4-5 clk cycles after the ncs pin rises. wr_strobe lasts exactly 1 cycle.
- cipo changes no later than 4 clk cycles after an sclk pin falling edge, and never within 3 clk cycles after an sclk rising edge.
- If a sclk rising edge and an ncs rising edge are detected in the same cycle, ncs wins and the bit is dropped (count unchanged).
- If an ncs falling edge is detected in the COMMIT cycle, it is ignored. The next frame requires ncs to go high and then low again.
- Back-to-back frames require ncs high for at least 6 clk cycles.

## Test plan
- Reset, then write frame 0x8355 (defaults): reg 3 = 0x55 and wr_strobe pulses once with wr_addr = 3. All other registers stay 0.
- Write reg 5 = 0xA7, then read frame 0x05xx: cipo_oe rises after the 8th sclk. Controller samples 0xA7 on sclk edges 9-16, and reg 5 is unchanged.
- Short frame (12 sclks) and long frame (18 sclks) writing reg 1: no register change, no wr_strobe, and frame_err pulses once per frame.
- Write to address 0x7F (>= NUM_REGS): no change and no wr_strobe. A read of 0x7F returns 0x00.
- Assert rst_n low for 2 cycles mid-frame, with ncs held low through release: all outputs are 0. The remainder of that frame is ignored. The next complete frame writes correctly.
- Run the first scenario again with NUM_REGS=32, ADDR_W=5, DATA_W=16 and a 22-bit frame writing reg 31 = 0xBEEF: regs_flat[511:496] = 0xBEEF, and the same value reads back.
